cmd_issuer: RTL

CMD_ISSUER -- requirements
Module: cmd_issuer

---
 rtl/cmd_pkg.sv | 35 +++
 rtl/cmd_timeout_ctr.sv | 29 ++
 rtl/cmd_issuer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared constants for the command issuer: opcodes, frame size,
// FSM encoding and small arithmetic helpers.
package cmd_pkg;

   localparam logic [7:0] READ_DATA  = 8'd0;
   localparam logic [7:0] CLKSWITCH  = 8'd1;
   localparam logic [7:0] VERSION    = 8'd2;
   localparam logic [7:0] SPI        = 8'd3;
   localparam logic [7:0] FIFOTEST   = 8'd4;
   localparam logic [7:0] SET_LENGTH = 8'd5;
   localparam logic [7:0] FIFO_USED  = 8'd6;

   localparam int CMD_BYTES = 8;
   localparam int IDX_W     = $clog2(CMD_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_RSP,
      ST_RECV,
      ST_DONE
   } state_e;

   function automatic logic [2:0] popcnt4(input logic [3:0] k);
      return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [2:0]  b);
      logic [32:0] s;
      s = {1'b0, a} + {30'd0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Response watchdog: counts enabled cycles, expires at TIMEOUT_CYCLES-1.
module cmd_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)       cnt_d = '0;
      else if (enable) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expire = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmd_issuer.sv
// Command issuer: streams an 8-byte command, then collects the response.
// Watchdog present only when CMD_ISSUER_TIMEOUT_EN is defined.
module cmd_issuer
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_data,
   input  logic [31:0] cmd_rsp_len,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [7:0]  o_tdata,
   input  logic        i_tvalid,
   output logic        i_tready,
   input  logic [31:0] i_tdata,
   input  logic [3:0]  i_tkeep,
   input  logic        i_tlast,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_keep,
   output logic        done,
   output logic [31:0] rsp_bytes,
   output logic        err_short,
   output logic        err_timeout
);

   state_e             state_q, state_d;
   logic [63:0]        cmd_q, cmd_d;
   logic [31:0]        len_q, len_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        bytes_q, bytes_d;
   logic               es_q, es_d;
   logic               et_q, et_d;
   logic               rv_q, rv_d;
   logic [31:0]        rd_q, rd_d;
   logic [3:0]         rk_q, rk_d;

   logic               wait_st;
   logic               beat;
   logic               tmo_hit;
   logic [31:0]        new_bytes;

   assign wait_st   = (state_q == ST_WAIT_RSP) || (state_q == ST_RECV);
   assign beat      = i_tvalid && wait_st;
   assign new_bytes = sat_add(bytes_q, popcnt4(i_tkeep));

`ifdef CMD_ISSUER_TIMEOUT_EN
   cmd_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clear  (beat || !wait_st),
      .enable (wait_st),
      .expire (tmo_hit)
   );
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bytes_d = bytes_q;
      es_d    = es_q;
      et_d    = et_q;
      rv_d    = 1'b0;
      rd_d    = rd_q;
      rk_d    = rk_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               cmd_d   = cmd_data;
               len_d   = cmd_rsp_len;
               bytes_d = '0;
               es_d    = 1'b0;
               et_d    = 1'b0;
               idx_d   = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (o_tready) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(CMD_BYTES - 1))
                  state_d = (len_q == '0) ? ST_DONE : ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP, ST_RECV: begin
            // An accepted beat takes priority over a same-cycle expiry.
            if (beat) begin
               rv_d    = 1'b1;
               rd_d    = i_tdata;
               rk_d    = i_tkeep;
               bytes_d = new_bytes;
               state_d = ST_RECV;
               if (i_tlast || (new_bytes >= len_q)) begin
                  es_d    = i_tlast && (new_bytes < len_q);
                  state_d = ST_DONE;
               end
            end else if (tmo_hit) begin
               et_d    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         bytes_q <= '0;
         es_q    <= 1'b0;
         et_q    <= 1'b0;
         rv_q    <= 1'b0;
         rd_q    <= '0;
         rk_q    <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bytes_q <= bytes_d;
         es_q    <= es_d;
         et_q    <= et_d;
         rv_q    <= rv_d;
         rd_q    <= rd_d;
         rk_q    <= rk_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign o_tvalid    = (state_q == ST_SEND);
   assign o_tdata     = cmd_q[{idx_q, 3'b000} +: 8];
   assign i_tready    = wait_st;
   assign rsp_valid   = rv_q;
   assign rsp_data    = rd_q;
   assign rsp_keep    = rk_q;
   assign done        = (state_q == ST_DONE);
   assign rsp_bytes   = bytes_q;
   assign err_short   = es_q;
   assign err_timeout = et_q;

endmodule
